// File: rtl/colmult_pkg.sv
// Shared field/column sizing, element types and round-robin helper for the
// column-multiplier scheduler.
package colmult_pkg;

  localparam int GF_M   = 13;
  localparam int N_PROD = 16;

  typedef logic [GF_M-1:0]        gf_elem_t;
  typedef gf_elem_t [N_PROD-1:0]  colmult_prod_t;

  // Next requester index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/colmult_rr_arb.sv
// Round-robin arbiter: one-hot grant from req_valid searching upward from
// rr_ptr; the pointer moves past the winner only when a grant is taken.
module colmult_rr_arb #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             accept
);
  import colmult_pkg::*;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] scan_id;
  logic            found;
  int              scan_idx;

  always_comb begin
    gnt_id   = '0;
    found    = 1'b0;
    scan_idx = 0;
    scan_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      scan_id = scan_idx[ID_W-1:0];
      if (!found && req_valid[scan_id]) begin
        found  = 1'b1;
        gnt_id = scan_id;
      end
    end
    accept   = en && found;
    gnt      = accept ? (N_REQ'(1) << gnt_id) : '0;
    rr_ptr_d = accept ? ID_W'(rr_next(int'(gnt_id), N_REQ)) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/colmult_rr_sched.sv
// Round-robin scheduler sharing one GF(2^m) constant-multiplier column among
// N_REQ requesters. Optional stall counter: define COLMULT_STALL_CNT_EN.
module colmult_rr_sched #(
  parameter  int N_REQ  = 4,
  parameter  int GF_M   = colmult_pkg::GF_M,
  parameter  int N_PROD = colmult_pkg::N_PROD,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*GF_M-1:0]  req_b,
  output logic [GF_M-1:0]        mul_b,
  input  logic [N_PROD*GF_M-1:0] mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [N_PROD*GF_M-1:0] rsp_p,
  output logic                   busy
`ifdef COLMULT_STALL_CNT_EN
  ,
  input  logic                   stall_clr,
  output logic [15:0]            stall_cnt
`endif
);
  import colmult_pkg::*;

  logic                   a_vld_q, a_vld_d;
  logic [ID_W-1:0]        a_id_q, a_id_d;
  logic [GF_M-1:0]        a_b_q, a_b_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
  logic [N_PROD*GF_M-1:0] rsp_p_q, rsp_p_d;

  logic                   b_load, a_free, arb_en, accept;
  logic [ID_W-1:0]        gnt_id;

  assign b_load = a_vld_q && (!rsp_valid_q || rsp_ready);
  assign a_free = !a_vld_q || b_load;
  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign arb_en = a_free && rst_n;

  colmult_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .req_valid (req_valid),
    .gnt       (req_ready),
    .gnt_id    (gnt_id),
    .accept    (accept)
  );

  // Stage A: operand register feeding the shared column
  always_comb begin
    a_vld_d = a_vld_q;
    a_id_d  = a_id_q;
    a_b_d   = a_b_q;
    if (accept) begin
      a_vld_d = 1'b1;
      a_id_d  = gnt_id;
      a_b_d   = req_b[gnt_id*GF_M +: GF_M];
    end else if (b_load) begin
      a_vld_d = 1'b0;
    end
  end

  // Stage B: product capture tagged with the requester id
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    if (b_load) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = a_id_q;
      rsp_p_d     = mul_p;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q     <= 1'b0;
      a_id_q      <= '0;
      a_b_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_id_q      <= a_id_d;
      a_b_q       <= a_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
    end
  end

  assign mul_b     = a_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = a_vld_q || rsp_valid_q;

`ifdef COLMULT_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)                      stall_cnt_d = '0;
    else if (rsp_valid_q && !rsp_ready) stall_cnt_d = sat_inc16(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/colmult_rr_sched.md
Name: colmult_rr_sched

Overview:
- Round-robin scheduler that shares one combinational GF(2^13) constant-multiplier column among N_REQ requesters. The column is 13-bit input, 16 products.
- Accepts operand b from the granted requester and drives it to the column through a registered stage.
- Captures the 16 products into a response register tagged with the requester ID.
- Sits between the key-equation/Chien requesters and the shared multiplier column in the BCH decoder datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- GF_M, 13, field element width
- N_PROD, 16, products per column
- ID_W, $clog2(N_REQ), requester ID width (derived, localparam)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_b  in  N_REQ*GF_M  per-requester operand; slice i = req_b[i*GF_M +: GF_M]
- mul_b  out  GF_M  operand to multiplier column (registered)
- mul_p  in  N_PROD*GF_M  products from column; P1 in bits [GF_M-1:0]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  requester index of response
- rsp_p  out  N_PROD*GF_M  registered products
- busy  out  1  any stage occupied

Behaviour:
- Two-stage pipeline.
  - Stage A (op): a_vld, a_id, a_b; a_b drives mul_b.
  - Stage B (rsp): rsp_valid, rsp_id, rsp_p.
- Reset: a_vld=0, a_b=0, a_id=0, rsp_valid=0, rsp_id=0, rsp_p=0, rr_ptr=0, req_ready=0, busy=0.
- Stall rules:
  - B advance (b_load) = a_vld && (!rsp_valid || rsp_ready).
  - A free (a_free) = !a_vld || b_load.
- Grant: when a_free, grant the first i with req_valid[i] set, searching from rr_ptr upward modulo N_REQ.
  - req_ready[grant]=1 in the same cycle (combinational from req_valid, rr_ptr and pipeline state).
- Accept (req_valid[i] && req_ready[i]): a_b<=req_b slice i, a_id<=i, a_vld<=1, rr_ptr<=(i+1) mod N_REQ.
  - rr_ptr changes only on accept.
- On b_load: rsp_p<=mul_p, rsp_id<=a_id, rsp_valid<=1. If no new accept that cycle, a_vld<=0.
- rsp_valid && rsp_ready && !b_load -> rsp_valid<=0.
- Latency: accept at edge k, rsp_valid at edge k+1; throughput 1 op/cycle with rsp_ready=1.
- Backpressure: while rsp_valid && !rsp_ready, rsp_* and mul_b are held stable. Stage A holds; req_ready=0 once A is full.
- Requester rules:
  - Must hold req_valid and req_b stable until accepted.
  - Deasserting before accept is a protocol violation (assert in bench).
- Fairness: a continuously asserting requester is granted within N_REQ accepts.
- Simultaneous accept into A and load into B in one cycle is the normal full-throughput case. No bubble.
- rsp_ready with rsp_valid=0 has no effect.
- busy = a_vld || rsp_valid.
- Reset asserted mid-operation: all stages flush immediately (async). In-flight ops are lost and no response is produced. rr_ptr returns to 0.
- mul_p is sampled only on b_load. X on mul_p outside b_load is ignored.

Optional Feature:
- COLMULT_STALL_CNT_EN defined:
  - Adds output stall_cnt (16 bits), reset 0.
  - Increments each cycle rsp_valid && !rsp_ready; saturates at 16'hFFFF.
  - Adds input stall_clr (1 bit) that synchronously zeroes the counter. Clear has priority over increment.
- Not defined: ports absent, no counter logic.

Decomposition:
- colmult_pkg:
  - GF_M=13, N_PROD=16.
  - typedef gf_elem_t (logic [GF_M-1:0]).
  - typedef colmult_prod_t (gf_elem_t [N_PROD-1:0]).
- One sub-module: colmult_rr_arb. It holds the round-robin pointer and does combinational one-hot grant from req_valid, enable and rr_ptr, with update on accept.
- The multiplier column is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req_valid=4'b0100, req_b[2]=13'h0001, rsp_ready=1.
  - Expect req_ready=4'b0100 on that cycle and mul_b=13'h0001 the next cycle.
  - rsp_valid=1 with rsp_id=2 one cycle after accept, and rsp_p equal to the golden products of b=1.
  - rr_ptr becomes 3.
- All four requesters valid continuously, rsp_ready=1.
  - Expect grants in order 0,1,2,3,0,... one per cycle.
  - rsp_id stream 0,1,2,3 with no bubbles.
- Backpressure: rsp_ready=0 for 5 cycles with 2 ops issued.
  - rsp_* is stable and A holds the 2nd op; req_ready=0 while A is full.
  - On rsp_ready=1 both responses drain in consecutive cycles, in order.
- Random b (1000 ops, random valids and rsp_ready).
  - Every rsp_p equals the reference-model product column for the accepted b, with correct rsp_id.
  - No op is lost or duplicated.
- Reset: assert rst_n=0 while both stages are full.
  - All outputs go to reset values asynchronously; after release, the first grant goes to requester 0 if it is valid.
- COLMULT_STALL_CNT_EN: hold rsp_valid with rsp_ready=0 for 70000 cycles.
  - stall_cnt=16'hFFFF.
  - stall_clr pulse -> 0 next cycle, even while still stalled.
